// File: rtl/mips_single_cycle_core_if.sv
// Fetch-address / decode-status bundle between the core and the external next-PC logic.
interface mips_single_cycle_core_if;
  logic [7:0]  ReadAddr;
  logic [31:0] SEImm;
  logic [25:0] JumpValue;
  logic        Zero;
  logic        Branch;
  logic        Jump;

  modport master (output ReadAddr, input SEImm, JumpValue, Zero, Branch, Jump);
  modport slave  (input ReadAddr, output SEImm, JumpValue, Zero, Branch, Jump);
endinterface

// File: rtl/mips_single_cycle_core.sv
// Single-cycle MIPS datapath: combinational fetch/decode/execute from ReadAddr,
// register-file and data-memory writes commit on the falling clock edge.
module mips_imem (
  input  logic [7:0]  addr_i,
  output logic [31:0] instr_o
);
  logic [7:0] IM [0:255];
  logic [7:0] a1, a2, a3;

  assign a1 = addr_i + 8'd1;
  assign a2 = addr_i + 8'd2;
  assign a3 = addr_i + 8'd3;
  assign instr_o = {IM[addr_i], IM[a1], IM[a2], IM[a3]};
endmodule

module mips_dmem (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  addr_i,
  input  logic        we_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o
);
  logic [7:0] DM [0:255];
  logic [7:0] a1, a2, a3;

  assign a1 = addr_i + 8'd1;
  assign a2 = addr_i + 8'd2;
  assign a3 = addr_i + 8'd3;
  assign rd_o = {DM[addr_i], DM[a1], DM[a2], DM[a3]};

  // Contents survive reset; reset only blocks the write on that edge.
  always_ff @(negedge clk) begin
    if (!reset && we_i) begin
      DM[addr_i] <= wd_i[31:24];
      DM[a1]     <= wd_i[23:16];
      DM[a2]     <= wd_i[15:8];
      DM[a3]     <= wd_i[7:0];
    end
  end
endmodule

module mips_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic [4:0]  wa_i,
  input  logic        we_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] RF [0:31];

  assign rd1_o = (ra1_i == 5'd0) ? '0 : RF[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? '0 : RF[ra2_i];

  always_ff @(negedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) RF[i[4:0]] <= '0;
    end else if (we_i && wa_i != 5'd0) begin
      RF[wa_i] <= wd_i;
    end
  end
endmodule

module mips_eu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_i,
  input  logic [31:0] dm_rdata_i,
  output logic [7:0]  dm_addr_o,
  output logic [31:0] dm_wdata_o,
  output logic        dm_we_o,
  output logic [31:0] seimm_o,
  output logic [25:0] jump_value_o,
  output logic        zero_o,
  output logic        branch_o,
  output logic        jump_o
);
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  logic [5:0]  op, funct;
  logic        reg_we, reg_dst_rd, alu_src_imm, mem_to_reg;
  alu_op_e     alu_op;
  logic [31:0] rs_data, rt_data, alu_b, alu_y, wb_data;
  logic [4:0]  wa;

  assign op           = instr_i[31:26];
  assign funct        = instr_i[5:0];
  assign seimm_o      = {{16{instr_i[15]}}, instr_i[15:0]};
  assign jump_value_o = instr_i[25:0];

  always_comb begin
    reg_we      = 1'b0;
    reg_dst_rd  = 1'b0;
    alu_src_imm = 1'b0;
    mem_to_reg  = 1'b0;
    dm_we_o     = 1'b0;
    branch_o    = 1'b0;
    jump_o      = 1'b0;
    alu_op      = ALU_ADD;
    case (op)
      6'h00: begin
        reg_we     = 1'b1;
        reg_dst_rd = 1'b1;
        case (funct)
          6'h20:   alu_op = ALU_ADD;
          6'h22:   alu_op = ALU_SUB;
          6'h24:   alu_op = ALU_AND;
          6'h25:   alu_op = ALU_OR;
          6'h2A:   alu_op = ALU_SLT;
          default: reg_we = 1'b0;
        endcase
      end
      6'h23: begin
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
        mem_to_reg  = 1'b1;
      end
      6'h2B: begin
        dm_we_o     = 1'b1;
        alu_src_imm = 1'b1;
      end
      6'h04: begin
        alu_op   = ALU_SUB;
        branch_o = 1'b1;
      end
      6'h02:   jump_o = 1'b1;
      default: ;
    endcase
  end

  assign alu_b = alu_src_imm ? seimm_o : rt_data;

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD: alu_y = rs_data + alu_b;
      ALU_SUB: alu_y = rs_data - alu_b;
      ALU_AND: alu_y = rs_data & alu_b;
      ALU_OR:  alu_y = rs_data | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(rs_data) < $signed(alu_b)};
      default: alu_y = '0;
    endcase
  end

  assign zero_o     = (alu_y == '0);
  assign dm_addr_o  = alu_y[7:0];
  assign dm_wdata_o = rt_data;
  assign wb_data    = mem_to_reg ? dm_rdata_i : alu_y;
  assign wa         = reg_dst_rd ? instr_i[15:11] : instr_i[20:16];

  mips_regfile RF32 (
    .clk   (clk),
    .reset (reset),
    .ra1_i (instr_i[25:21]),
    .ra2_i (instr_i[20:16]),
    .wa_i  (wa),
    .we_i  (reg_we),
    .wd_i  (wb_data),
    .rd1_o (rs_data),
    .rd2_o (rt_data)
  );
endmodule

module mips_single_cycle_core (
  input  logic                      clk,
  input  logic                      reset,
  mips_single_cycle_core_if.slave   bus
);
  logic [31:0] instr, dm_rdata, dm_wdata;
  logic [7:0]  dm_addr;
  logic        dm_we;

  mips_imem IMEM (
    .addr_i  (bus.ReadAddr),
    .instr_o (instr)
  );

  mips_dmem DMEM (
    .clk    (clk),
    .reset  (reset),
    .addr_i (dm_addr),
    .we_i   (dm_we),
    .wd_i   (dm_wdata),
    .rd_o   (dm_rdata)
  );

  mips_eu eu1 (
    .clk          (clk),
    .reset        (reset),
    .instr_i      (instr),
    .dm_rdata_i   (dm_rdata),
    .dm_addr_o    (dm_addr),
    .dm_wdata_o   (dm_wdata),
    .dm_we_o      (dm_we),
    .seimm_o      (bus.SEImm),
    .jump_value_o (bus.JumpValue),
    .zero_o       (bus.Zero),
    .branch_o     (bus.Branch),
    .jump_o       (bus.Jump)
  );
endmodule

// File: tb/tb_mips_single_cycle_core.sv
// Directed bench: preloads IM/DM/RF hierarchically, steps ReadAddr through a small program.
module tb_mips_single_cycle_core;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [7:0]  dm_init [0:255];
  logic [31:0] prog [0:10];

  mips_single_cycle_core_if bus ();

  mips_single_cycle_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sel(input logic [7:0] a);
    @(posedge clk);
    #1 bus.ReadAddr = a;
    #1;
  endtask

  task automatic commit();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rf(input int unsigned i);
    return dut.eu1.RF32.RF[i];
  endfunction

  function automatic logic [31:0] dmw(input int unsigned a);
    return {dut.DMEM.DM[a % 256], dut.DMEM.DM[(a + 1) % 256],
            dut.DMEM.DM[(a + 2) % 256], dut.DMEM.DM[(a + 3) % 256]};
  endfunction

  initial begin
    prog[0]  = 32'h02cdf824; // and $31,$22,$13
    prog[1]  = 32'h0043082a; // slt $1,$2,$3
    prog[2]  = 32'h8e8c0014; // lw  $12,20($20)
    prog[3]  = 32'hac040000; // sw  $4,0($0)
    prog[4]  = 32'h10a6ffff; // beq $5,$6,-1
    prog[5]  = 32'h01093822; // sub $7,$8,$9
    prog[6]  = 32'h08100004; // j   0x00400010
    prog[7]  = 32'h0062082a; // slt $1,$3,$2
    prog[8]  = 32'h10000000; // beq $0,$0,0
    prog[9]  = 32'h00210020; // add $0,$1,$1
    prog[10] = 32'h8c0dfffe; // lw  $13,-2($0)

    reset = 1'b0;
    bus.ReadAddr = 8'd0;
    for (int i = 0; i < 256; i++) begin
      dut.IMEM.IM[i] = 8'h00;
      dm_init[i] = 8'($urandom);
      dut.DMEM.DM[i] = dm_init[i];
    end
    for (int k = 0; k < 11; k++) begin
      dut.IMEM.IM[4*k]   = prog[k][31:24];
      dut.IMEM.IM[4*k+1] = prog[k][23:16];
      dut.IMEM.IM[4*k+2] = prog[k][15:8];
      dut.IMEM.IM[4*k+3] = prog[k][7:0];
    end
    for (int i = 0; i < 32; i++) dut.eu1.RF32.RF[i] = 32'(i);
    #1;

    // and: outputs settle combinationally, RF[31] keeps old value until the falling edge
    chk("and_seimm", bus.SEImm, 32'hfffff824);
    chk("and_zero", {31'd0, bus.Zero}, 32'd0);
    chk("and_branch", {31'd0, bus.Branch}, 32'd0);
    chk("and_jump", {31'd0, bus.Jump}, 32'd0);
    chk("and_rf31_before", rf(31), 32'd31);
    commit();
    chk("and_rf31", rf(31), 32'h00000004);

    sel(8'd28); commit();
    chk("slt_false", rf(1), 32'h00000000);
    sel(8'd4);  commit();
    chk("slt_true", rf(1), 32'h00000001);

    sel(8'd8);  commit();
    chk("lw_rf12", rf(12), {dm_init[40], dm_init[41], dm_init[42], dm_init[43]});

    sel(8'd12); commit();
    chk("sw_dm0", dmw(0), 32'h00000004);

    sel(8'd16);
    chk("beq_zero", {31'd0, bus.Zero}, 32'd0);
    chk("beq_branch", {31'd0, bus.Branch}, 32'd1);
    chk("beq_jump", {31'd0, bus.Jump}, 32'd0);
    chk("beq_seimm", bus.SEImm, 32'hffffffff);
    commit();
    chk("beq_rf5", rf(5), 32'd5);
    chk("beq_rf6", rf(6), 32'd6);
    chk("beq_dm0", dmw(0), 32'h00000004);

    sel(8'd20); commit();
    chk("sub_rf7", rf(7), 32'hffffffff);

    sel(8'd24);
    chk("j_value", {6'd0, bus.JumpValue}, 32'h00100004);
    chk("j_jump", {31'd0, bus.Jump}, 32'd1);
    chk("j_branch", {31'd0, bus.Branch}, 32'd0);
    commit();

    sel(8'd32);
    chk("beq_eq_zero", {31'd0, bus.Zero}, 32'd1);
    chk("beq_eq_seimm", bus.SEImm, 32'h00000000);
    commit();

    sel(8'd36); commit();
    chk("add_r0_discard", rf(0), 32'd0);

    // lw wrapping past DM[255]; DM[0..1] were zeroed by the earlier sw
    sel(8'd40); commit();
    chk("lw_wrap", rf(13), {dm_init[254], dm_init[255], 16'h0000});

    sel(8'd100);
    dut.DMEM.DM[0] = 8'hAA;
    dut.DMEM.DM[1] = 8'hBB;
    dut.DMEM.DM[2] = 8'hCC;
    dut.DMEM.DM[3] = 8'hDD;
    @(posedge clk);
    #1 bus.ReadAddr = 8'd12;
    reset = 1'b1;
    commit();
    for (int i = 0; i < 32; i++) chk($sformatf("reset_rf%0d", i), rf(i), 32'd0);
    chk("reset_dm_kept", dmw(0), 32'hAABBCCDD);
    chk("reset_dm40_kept", dmw(40), {dm_init[40], dm_init[41], dm_init[42], dm_init[43]});
    @(posedge clk);
    #1 reset = 1'b0;
    commit();
    chk("post_reset_sw", dmw(0), 32'h00000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
